matrix_scan: RTL and testbench

MATRIX_SCAN -- requirements
Module: matrix_scan

---
 rtl/lava_pkg.sv | 17 +
 rtl/bcm_timer.sv | 19 +
 rtl/matrix_scan.sv | 101 ++++++++++
 tb/tb_matrix_scan.sv | 138 +++++++++++++
 4 files changed

// File: rtl/lava_pkg.sv
// lava_pkg: shared sizes, state encodings and pixel bit-plane helper for the HUB75 scanner.
package lava_pkg;
  localparam int PIX_W = 12;
  localparam int ADDR_W = 10;
  localparam int COLS = 32;
  localparam int ROWS = 32;
  localparam int SCAN_ROWS = 16;
  localparam int PLANES = 4;
  localparam int COL_W = $clog2(COLS);
  localparam int ROW_W = $clog2(SCAN_ROWS);
  localparam int PLANE_W = $clog2(PLANES);
  typedef enum logic [2:0] {RESET_IDLE, SHIFT, LATCH, DISPLAY, GAP} scan_state_t;
  typedef enum logic [1:0] {RD_TOP, RD_BOT, OUT_LO, OUT_HI} shift_phase_t;
  function automatic logic [2:0] plane_bits(input logic [PIX_W-1:0] pix, input logic [PLANE_W-1:0] p);
    return {pix[8+p], pix[4+p], pix[p]};
  endfunction
endpackage

// File: rtl/bcm_timer.sv
// bcm_timer: loadable down-counter timing one bit-plane's display window.
module bcm_timer #(
  parameter int W = 14
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] val,
  output logic         busy,
  output logic         done
);
  logic [W-1:0] cnt;
  assign busy = cnt != '0;
  assign done = !busy;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (load) cnt <= val;
    else if (busy) cnt <= cnt - 1'b1;
endmodule

// File: rtl/matrix_scan.sv
// matrix_scan: 32x32 1/16-scan HUB75 driver with 4-plane binary-coded modulation.
module matrix_scan
  import lava_pkg::*;
#(
  parameter int BASE_TIME = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_ready,
  input  logic [PIX_W-1:0]  pix_in,
  output logic [ADDR_W-1:0] r_addr,
  output logic              swap_en,
  output logic              frame_done,
  output logic [2:0]        rgb_top,
  output logic [2:0]        rgb_bot,
  output logic [ROW_W-1:0]  row_sel,
  output logic              sclk,
  output logic              lat,
  output logic              oe_n
);
  localparam int TW = $clog2(BASE_TIME * 8 + 1);
  scan_state_t st, st_n;
  shift_phase_t ph, ph_n;
  logic [COL_W-1:0] col, col_n;
  logic [PLANE_W-1:0] plane, plane_n;
  logic [ROW_W-1:0] row, row_n;
  logic [2:0] top_bits;
  logic eof, tmr_busy, tmr_done;
  bcm_timer #(.W(TW)) u_timer (
    .clk (clk),
    .rst (rst),
    .load(st == LATCH),
    .val (TW'(BASE_TIME) << plane),
    .busy(tmr_busy),
    .done(tmr_done)
  );
  always_comb begin
    st_n = st;
    ph_n = ph;
    col_n = col;
    plane_n = plane;
    row_n = row;
    eof = st == DISPLAY && tmr_done && plane == PLANE_W'(PLANES - 1) && row == ROW_W'(SCAN_ROWS - 1);
    case (st)
      RESET_IDLE, GAP: st_n = SHIFT;
      SHIFT: begin
        ph_n = shift_phase_t'(ph + 2'd1);
        if (ph == OUT_HI) begin
          col_n = col + 1'b1;
          st_n = col == COL_W'(COLS - 1) ? LATCH : SHIFT;
        end
      end
      LATCH: st_n = DISPLAY;
      DISPLAY: if (tmr_done) begin
        plane_n = plane + 1'b1;
        row_n = plane == PLANE_W'(PLANES - 1) ? row + 1'b1 : row;
        st_n = eof ? GAP : SHIFT;
      end
      default: st_n = RESET_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st <= RESET_IDLE;
      ph <= RD_TOP;
      col <= '0;
      plane <= '0;
      row <= '0;
    end else begin
      st <= st_n;
      ph <= ph_n;
      col <= col_n;
      plane <= plane_n;
      row <= row_n;
    end
  // r_addr is loaded from the next-state values so it is already on the bus during RD_TOP/RD_BOT.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_addr <= '0;
      top_bits <= '0;
      rgb_top <= '0;
      rgb_bot <= '0;
      row_sel <= '0;
      sclk <= 1'b0;
      lat <= 1'b0;
      oe_n <= 1'b1;
      frame_done <= 1'b0;
      swap_en <= 1'b0;
    end else begin
      r_addr <= st_n != SHIFT ? r_addr : ph_n == RD_TOP ? {1'b0, row_n, col_n} : ph_n == RD_BOT ? {1'b1, row_n, col_n} : r_addr;
      top_bits <= st == SHIFT && ph == RD_BOT ? plane_bits(pix_in, plane) : top_bits;
      rgb_top <= st == SHIFT && ph == OUT_LO ? top_bits : rgb_top;
      rgb_bot <= st == SHIFT && ph == OUT_LO ? plane_bits(pix_in, plane) : rgb_bot;
      sclk <= st == SHIFT && ph == OUT_HI;
      lat <= st == LATCH;
      row_sel <= st == LATCH ? row : row_sel;
      oe_n <= !(st == DISPLAY && tmr_busy);
      frame_done <= eof;
      swap_en <= eof && frame_ready;
    end
endmodule

// File: tb/tb_matrix_scan.sv
// tb_matrix_scan: frame-level vectors plus a pixel/timing reference model for matrix_scan.
module tb_matrix_scan;
  localparam int BT = 4;
  logic clk = 1'b0, rst = 1'b1, frame_ready = 1'b0;
  logic [11:0] pix_in;
  logic [9:0] r_addr;
  logic swap_en, frame_done, sclk, lat, oe_n;
  logic [2:0] rgb_top, rgb_bot;
  logic [3:0] row_sel;
  matrix_scan #(.BASE_TIME(BT)) dut (
    .clk(clk), .rst(rst), .frame_ready(frame_ready), .pix_in(pix_in), .r_addr(r_addr),
    .swap_en(swap_en), .frame_done(frame_done), .rgb_top(rgb_top), .rgb_bot(rgb_bot),
    .row_sel(row_sel), .sclk(sclk), .lat(lat), .oe_n(oe_n)
  );
  always #5 clk = ~clk;
  logic [11:0] mem [2][1024];
  logic sel = 1'b0;
  always @(posedge clk) begin
    pix_in <= mem[sel][r_addr];
    if (swap_en) sel <= !sel;
  end
  int checks = 0, failures = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  function automatic logic [2:0] bits_of(input logic [11:0] p, input int pl);
    logic [11:0] s;
    s = p >> pl;
    return {s[8], s[4], s[0]};
  endfunction
  task automatic check_reset_outputs(input string tag);
    check({tag, "_r_addr"}, r_addr, 0);
    check({tag, "_swap_en"}, swap_en, 0);
    check({tag, "_frame_done"}, frame_done, 0);
    check({tag, "_rgb_top"}, rgb_top, 0);
    check({tag, "_rgb_bot"}, rgb_bot, 0);
    check({tag, "_row_sel"}, row_sel, 0);
    check({tag, "_sclk"}, sclk, 0);
    check({tag, "_lat"}, lat, 0);
    check({tag, "_oe_n"}, oe_n, 1);
  endtask
  int cyc = 0, k = 0, msel = 0, run = 0, j = 0, nl = 0;
  logic psclk = 1'b0;
  logic [3:0] prow = '0;
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      k = 0; run = 0; j = 0; nl = 0; psclk = 1'b0; prow = '0;
    end else begin
      if (sclk && !psclk) begin
        check("rgb_top", rgb_top, bits_of(mem[msel][(k / 128) * 32 + k % 32], (k / 32) % 4));
        check("rgb_bot", rgb_bot, bits_of(mem[msel][(k / 128 + 16) * 32 + k % 32], (k / 32) % 4));
        k++;
        if (k == 2048) begin
          k = 0;
          if (frame_ready) msel ^= 1;
        end
      end
      psclk = sclk;
      if (!oe_n) run++;
      else if (run > 0) begin
        check("oe_low_len", run, BT << (j % 4));
        j++;
        run = 0;
      end
      if (lat) begin
        check("lat_oe_n", oe_n, 1);
        check("row_sel_at_lat", row_sel, (nl / 4) % 16);
        nl++;
      end
      if (row_sel !== prow) check("row_sel_change_lat_oe", {lat, oe_n}, 2'b11);
      prow = row_sel;
      if (swap_en) check("swap_with_frame_done", frame_done, 1);
    end
  end
  typedef struct {logic ready; logic exp_swap; int exp_period;} frame_vec_t;
  frame_vec_t tab [4];
  initial begin
    int n, last_fd, nlat, spurious;
    logic [9:0] q[$];
    logic [9:0] exp_addr [6];
    tab[0] = '{1'b1, 1'b1, 0};
    tab[1] = '{1'b0, 1'b0, 9281};
    tab[2] = '{1'b1, 1'b1, 9281};
    tab[3] = '{1'b1, 1'b1, 9281};
    exp_addr = '{10'd0, 10'd512, 10'd1, 10'd513, 10'd2, 10'd514};
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < 1024; a++) mem[b][a] = 12'($urandom);
    frame_ready = tab[0].ready;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    #2 rst = 1'b0;
    last_fd = cyc;
    for (int i = 0; i < 4; i++) begin
      frame_ready = tab[i].ready;
      n = 0;
      do begin @(negedge clk); n++; end while (!frame_done && n < 20000);
      if (n >= 20000) check("frame_done_timeout", 0, 1);
      check("swap_en_at_frame_done", swap_en, tab[i].exp_swap);
      if (tab[i].exp_period != 0) check("frame_period", cyc - last_fd, tab[i].exp_period);
      last_fd = cyc;
      @(negedge clk);
      check("frame_done_width", frame_done, 0);
      check("swap_en_width", swap_en, 0);
    end
    nlat = 0;
    n = 0;
    while (nlat < 31 && n < 20000) begin
      @(negedge clk);
      n++;
      if (lat) nlat++;
    end
    if (n >= 20000) check("latch_timeout", 0, 1);
    repeat (6) @(negedge clk);
    check("mid_display_oe_n", oe_n, 0);
    check("mid_display_row_sel", row_sel, 7);
    #2 rst = 1'b1;
    #1 check_reset_outputs("async_reset");
    @(negedge clk);
    #2 rst = 1'b0;
    q.push_back(r_addr);
    spurious = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (r_addr !== q[$]) q.push_back(r_addr);
      if (frame_done || swap_en) spurious++;
    end
    for (int i = 0; i < 6; i++) check("post_reset_r_addr", q.size() > i ? q[i] : 10'h3ff, exp_addr[i]);
    check("post_reset_no_frame_done", spurious, 0);
    repeat (300) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
